// File: rtl/skid_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer_if
//  Description : Valid/ready stream bundle (payload, valid, ready).
//                master modport drives payload and valid and receives ready;
//                slave modport receives payload and valid and drives ready.
//  Ports       : data       - payload, DATA_SIZE bits
//                data_valid - payload qualifier from the master
//                data_ready - acceptance from the slave
//  Revision    : 1.0 - initial release
// ============================================================================
interface skid_buffer_if #(
    parameter int DATA_SIZE = 8
);
    logic [DATA_SIZE-1:0] data;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer
//  Description : Two-entry register slice for a valid/ready stream. Cuts the
//                timing path on payload, valid and ready: every output comes
//                straight from a flop. Sustains one transfer per cycle, keeps
//                order, never drops or duplicates words.
//  Ports       : clk_i      - clock, rising edge
//                rst_clk_ni - synchronous active-low reset
//                up_if      - upstream side (slave modport): data_i,
//                             data_valid_i in, data_ready_o out
//                dn_if      - downstream side (master modport): data_o,
//                             data_valid_o out, data_ready_i in
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer #(
    parameter int DATA_SIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_clk_ni,
    skid_buffer_if.slave        up_if,
    skid_buffer_if.master       dn_if
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_out;
    logic [DATA_SIZE-1:0] r_skid;
    logic                 r_valid;
    logic                 r_ready;

    logic                 w_in_fire;
    logic                 w_out_fire;

    // Both handshakes use the registered flags, so no input reaches an output
    // combinationally.
    assign w_in_fire  = up_if.data_valid & r_ready;
    assign w_out_fire = r_valid & dn_if.data_ready;

    // Valid and ready are kept as their own flops, updated alongside the
    // state, rather than decoded from it. That keeps ready low while reset is
    // held and raises it on the first edge after release.
    always_ff @(posedge clk_i) begin
        if (!rst_clk_ni) begin
            r_state <= S_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    r_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_out   <= up_if.data;
                        r_valid <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: begin
                            r_out <= up_if.data;
                        end
                        2'b10: begin
                            // Downstream stalled while a word arrived: park it
                            // and drop ready so at most this one word skids.
                            r_skid  <= up_if.data;
                            r_ready <= 1'b0;
                            r_state <= S_FULL;
                        end
                        2'b01: begin
                            r_valid <= 1'b0;
                            r_state <= S_EMPTY;
                        end
                        default: begin
                            r_state <= S_BUSY;
                        end
                    endcase
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        r_out   <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign up_if.data_ready = r_ready;
    assign dn_if.data       = r_out;
    assign dn_if.data_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_skid_buffer
//  Description : Scoreboard bench for skid_buffer. Stimulus pushes each
//                accepted word into an expected queue; a monitor pops and
//                compares on every downstream transfer and watches output
//                stability during stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_skid_buffer;

    localparam int DATA_SIZE = 8;

    logic clk;
    logic rst_n;

    skid_buffer_if #(.DATA_SIZE(DATA_SIZE)) up_if ();
    skid_buffer_if #(.DATA_SIZE(DATA_SIZE)) dn_if ();

    skid_buffer #(.DATA_SIZE(DATA_SIZE)) u_dut (
        .clk_i      (clk),
        .rst_clk_ni (rst_n),
        .up_if      (up_if.slave),
        .dn_if      (dn_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [DATA_SIZE-1:0] exp_q[$];
    int n_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded wait).
    task automatic send(input logic [DATA_SIZE-1:0] d);
        int w;
        w = 0;
        up_if.data       = d;
        up_if.data_valid = 1'b1;
        @(negedge clk);
        while (!up_if.data_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (up_if.data_ready) exp_q.push_back(d);
        else check("send_ready_timeout", {31'b0, up_if.data_ready}, 32'd1);
        @(posedge clk);
        #1;
        up_if.data_valid = 1'b0;
    endtask

    // Monitor: at the negedge the values seen are those sampled at the next
    // rising edge, so valid & ready here means a transfer on that edge.
    logic                 prev_rst   = 1'b0;
    logic                 prev_valid = 1'b0;
    logic                 prev_rdy   = 1'b0;
    logic [DATA_SIZE-1:0] prev_data  = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_rst && prev_valid && !prev_rdy) begin
                check("stall_hold_valid", {31'b0, dn_if.data_valid}, 32'd1);
                check("stall_hold_data", {24'b0, dn_if.data}, {24'b0, prev_data});
            end
            if (rst_n && dn_if.data_valid && dn_if.data_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {31'b0, dn_if.data_valid}, 32'd0);
                end else begin
                    check("scoreboard_data", {24'b0, dn_if.data}, {24'b0, exp_q.pop_front()});
                    n_out++;
                end
            end
            prev_rst   = rst_n;
            prev_valid = dn_if.data_valid;
            prev_rdy   = dn_if.data_ready;
            prev_data  = dn_if.data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int w;

        rst_n            = 1'b0;
        up_if.data       = '0;
        up_if.data_valid = 1'b0;
        dn_if.data_ready = 1'b0;

        // ---------------- reset release ----------------
        repeat (3) begin
            step();
            check("rst_ready", {31'b0, up_if.data_ready}, 32'd0);
            check("rst_valid", {31'b0, dn_if.data_valid}, 32'd0);
            check("rst_data", {24'b0, dn_if.data}, 32'h00);
        end
        rst_n = 1'b1;
        check("release_ready_before_edge", {31'b0, up_if.data_ready}, 32'd0);
        step();
        check("release_ready_after_edge", {31'b0, up_if.data_ready}, 32'd1);
        check("release_valid", {31'b0, dn_if.data_valid}, 32'd0);
        check("release_data", {24'b0, dn_if.data}, 32'h00);

        // ---------------- streaming ----------------
        dn_if.data_ready = 1'b1;
        send(8'h01);
        check("stream_data_1", {24'b0, dn_if.data}, 32'h01);
        check("stream_valid_1", {31'b0, dn_if.data_valid}, 32'd1);
        send(8'h02);
        check("stream_data_2", {24'b0, dn_if.data}, 32'h02);
        check("stream_ready_2", {31'b0, up_if.data_ready}, 32'd1);
        send(8'h03);
        check("stream_data_3", {24'b0, dn_if.data}, 32'h03);
        check("stream_ready_3", {31'b0, up_if.data_ready}, 32'd1);
        step();
        check("stream_drained", {31'b0, dn_if.data_valid}, 32'd0);

        // ---------------- stall / skid ----------------
        dn_if.data_ready = 1'b0;
        send(8'h10);
        check("stall_out_10", {24'b0, dn_if.data}, 32'h10);
        check("stall_ready_busy", {31'b0, up_if.data_ready}, 32'd1);
        send(8'h11);
        check("stall_ready_full", {31'b0, up_if.data_ready}, 32'd0);
        check("stall_out_still_10", {24'b0, dn_if.data}, 32'h10);
        step();
        step();
        check("stall_held_10", {24'b0, dn_if.data}, 32'h10);
        check("stall_ready_held_low", {31'b0, up_if.data_ready}, 32'd0);
        dn_if.data_ready = 1'b1;
        step();
        check("drain_out_11", {24'b0, dn_if.data}, 32'h11);
        check("drain_ready_back", {31'b0, up_if.data_ready}, 32'd1);
        step();
        check("drain_empty", {31'b0, dn_if.data_valid}, 32'd0);
        check("drain_all_out", exp_q.size(), 32'd0);

        // ---------------- reset while FULL ----------------
        dn_if.data_ready = 1'b0;
        send(8'h20);
        send(8'h21);
        check("pre_rst_full_ready", {31'b0, up_if.data_ready}, 32'd0);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", {31'b0, dn_if.data_valid}, 32'd0);
        check("mid_rst_data", {24'b0, dn_if.data}, 32'h00);
        check("mid_rst_ready", {31'b0, up_if.data_ready}, 32'd0);
        exp_q.delete();
        dn_if.data_ready = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (4) begin
            step();
            check("post_rst_no_stale", {31'b0, dn_if.data_valid}, 32'd0);
        end
        check("post_rst_ready", {31'b0, up_if.data_ready}, 32'd1);

        // ---------------- random traffic ----------------
        n_out = 0;
        done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 4096; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send(DATA_SIZE'($urandom_range(0, 255)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    dn_if.data_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dn_if.data_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 64) begin
            step();
            w++;
        end
        step();
        check("random_queue_empty", exp_q.size(), 32'd0);
        check("random_word_count", n_out, 32'd4096);
        check("random_final_idle", {31'b0, dn_if.data_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
